// File: rtl/stump_sequencer_pkg.sv
// Shared Stump definitions: FSM state encodings, opcode constants and CC flag
// positions, reused by the sequencer, the decoder and the datapath.
package stump_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_EXECUTE = 2'b01,
    ST_MEMORY  = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  localparam logic [2:0] OP_LDST = 3'b110;
  localparam logic [2:0] OP_BCC  = 3'b111;

  // Bit positions of the {N,Z,V,C} flags inside CC and flags_in.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam int WAIT_W = 8;

  function automatic logic [2:0] opcode_of(input logic [15:0] instr);
    return instr[15:13];
  endfunction

endpackage

// File: rtl/stump_sequencer_wait_timer.sv
// Memory wait counter: counts stalled cycles and reports when the next stalled
// cycle reaches TIMEOUT, then restarts from zero.
module stump_wait_timer
  import stump_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [WAIT_W-1:0] cnt;

  assign expired = count && (cnt == WAIT_W'(TIMEOUT - 1));

  // NOTE: sequential state is written with <= only, so every always_ff reads
  // the pre-edge value of every register regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n)                cnt <= '0;
    else if (clear || expired) cnt <= '0;
    else if (count)            cnt <= cnt + WAIT_W'(1);
  end

endmodule

// File: rtl/stump_sequencer.sv
// Stump sequencing stage: FSM, instruction register, condition codes, retired
// counter and sticky bus-error flag, with a ready-handshaked memory request.
module stump_sequencer
  import stump_sequencer_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [15:0]      mem_rdata,
  input  logic             cc_en,
  input  logic [3:0]       flags_in,
  output logic [1:0]       state,
  output logic [15:0]      ir,
  output logic [3:0]       cc,
  output logic             mem_req,
  output logic [CNT_W-1:0] retired,
  output logic             bus_error
);

  state_t state_q;
  logic   wait_clear;
  logic   wait_count;
  logic   expired;

  assign state   = state_q;
  assign mem_req = (state_q == ST_FETCH && run) || state_q == ST_MEMORY;

  // NOTE: both outputs get a default first so no path leaves them unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    wait_clear = 1'b0;
    wait_count = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (!run || mem_ready) wait_clear = 1'b1;
        else                   wait_count = 1'b1;
      end
      ST_MEMORY: begin
        if (mem_ready) wait_clear = 1'b1;
        else           wait_count = 1'b1;
      end
      default: ;
    endcase
  end

  stump_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wait_clear),
    .count   (wait_count),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ir        <= 16'h0000;
      cc        <= 4'b0000;
      retired   <= '0;
      bus_error <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (run && mem_ready) begin
            ir      <= mem_rdata;
            state_q <= ST_EXECUTE;
          end else if (expired) begin
            bus_error <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          // Branches read CC but never write it, whatever the decoder asks.
          if (cc_en && opcode_of(ir) != OP_BCC) cc <= flags_in;
          if (opcode_of(ir) == OP_LDST) begin
            state_q <= ST_MEMORY;
          end else begin
            state_q <= ST_FETCH;
            retired <= retired + CNT_W'(1);
          end
        end
        ST_MEMORY: begin
          if (mem_ready) begin
            state_q <= ST_FETCH;
            retired <= retired + CNT_W'(1);
          end else if (expired) begin
            bus_error <= 1'b1;
            state_q   <= ST_FETCH;
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

endmodule
